// File: rtl/mul_booth_slave.sv
// mul_booth_slave: bus-slave Booth multiplier (radix-2 or radix-4) with
// operand/result registers, start/clear/status/mode control and a level IRQ.
module mul_booth_slave #(
  parameter int N_WORDS = 2,
  parameter int RADIX4  = 1,
  parameter int ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [31:0]       s_din,
  output logic [31:0]       s_dout,
  output logic              m_interrupt
);

  localparam int W     = 32 * N_WORDS;
  localparam int SH    = (RADIX4 != 0) ? 2 : 1;          // multiplier bits per cycle
  localparam int CYC   = (RADIX4 != 0) ? W / 2 + 1 : W + 1;
  localparam int LB    = SH * CYC;                        // multiplier shift register width
  localparam int HW    = W + 4;                           // accumulator holds +-2A of W+2-bit A
  localparam int PW    = HW + LB;
  localparam int CNT_W = $clog2(CYC + 1);

  localparam int OFS_B      = N_WORDS;
  localparam int OFS_RES    = 2 * N_WORDS;
  localparam int OFS_START  = 4 * N_WORDS;
  localparam int OFS_CLEAR  = 4 * N_WORDS + 1;
  localparam int OFS_INTR   = 4 * N_WORDS + 2;
  localparam int OFS_STATUS = 4 * N_WORDS + 3;
  localparam int OFS_MODE   = 4 * N_WORDS + 4;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [W-1:0]       op_a_q, op_a_d, op_b_q, op_b_d;
  logic [2*W-1:0]     result_q, result_d;
  logic [HW-1:0]      acc_q, acc_d;
  logic [LB-1:0]      mplr_q, mplr_d;
  logic               prev_q, prev_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               intr_en_q, intr_en_d;
  logic               mode_q, mode_d;

  logic               wr_en, busy, done;
  logic               start_req, clear_req, stat_clr;
  logic [HW-1:0]      a_sx, pp, sum;
  logic [W+1:0]       b_ext;
  logic [PW-1:0]      prod_next;

  assign wr_en     = s_sel & s_wr;
  assign busy      = (state_q == S_EXEC);
  assign done      = (state_q == S_DONE);
  assign start_req = wr_en && (s_addr == ADDR_W'(OFS_START)) && s_din[0] && !busy;
  assign clear_req = wr_en && (s_addr == ADDR_W'(OFS_CLEAR)) && s_din[0];
  assign stat_clr  = wr_en && (s_addr == ADDR_W'(OFS_STATUS)) && s_din[0];

  assign m_interrupt = done & intr_en_q;

  // Booth step: recode low multiplier bits, add the scaled A, arithmetic shift right.
  always_comb begin
    a_sx  = {{4{mode_q & op_a_q[W-1]}}, op_a_q};
    b_ext = {{2{mode_q & op_b_q[W-1]}}, op_b_q};
    pp    = '0;
    if (RADIX4 != 0) begin
      case ({mplr_q[1:0], prev_q})
        3'b001, 3'b010: pp = a_sx;
        3'b011:         pp = a_sx << 1;
        3'b100:         pp = -(a_sx << 1);
        3'b101, 3'b110: pp = -a_sx;
        default:        pp = '0;
      endcase
    end else begin
      case ({mplr_q[0], prev_q})
        2'b01:   pp = a_sx;
        2'b10:   pp = -a_sx;
        default: pp = '0;
      endcase
    end
    sum       = acc_q + pp;
    prod_next = $signed({sum, mplr_q}) >>> SH;
  end

  // Bus-visible configuration registers; operands and mode are frozen while busy.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    intr_en_d = intr_en_q;
    mode_d    = mode_q;
    for (int i = 0; i < N_WORDS; i++) begin
      if (wr_en && !busy && (s_addr == ADDR_W'(i)))         op_a_d[i*32 +: 32] = s_din;
      if (wr_en && !busy && (s_addr == ADDR_W'(OFS_B + i))) op_b_d[i*32 +: 32] = s_din;
    end
    if (wr_en && (s_addr == ADDR_W'(OFS_INTR)))          intr_en_d = s_din[0];
    if (wr_en && !busy && (s_addr == ADDR_W'(OFS_MODE))) mode_d    = s_din[0];
  end

  // Control FSM and multiplier datapath next state; OPCLEAR overrides everything.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mplr_d   = mplr_q;
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (clear_req) begin
      state_d  = S_IDLE;
      result_d = '0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_req) begin
            state_d = S_EXEC;
            acc_d   = '0;
            mplr_d  = b_ext[LB-1:0];
            prev_d  = 1'b0;
            cnt_d   = '0;
          end else if (done && stat_clr) begin
            state_d = S_IDLE;
          end
        end
        S_EXEC: begin
          {acc_d, mplr_d} = prod_next;
          prev_d = (RADIX4 != 0) ? mplr_q[1] : mplr_q[0];
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(CYC - 1)) begin
            state_d  = S_DONE;
            result_d = prod_next[2*W-1:0];
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Combinational register read-back; zero unless a read is selected.
  always_comb begin
    s_dout = '0;
    if (s_sel && !s_wr) begin
      for (int i = 0; i < N_WORDS; i++) begin
        if (s_addr == ADDR_W'(i))         s_dout = op_a_q[i*32 +: 32];
        if (s_addr == ADDR_W'(OFS_B + i)) s_dout = op_b_q[i*32 +: 32];
      end
      for (int i = 0; i < 2 * N_WORDS; i++) begin
        if (s_addr == ADDR_W'(OFS_RES + i)) s_dout = result_q[i*32 +: 32];
      end
      if (s_addr == ADDR_W'(OFS_INTR))   s_dout = {31'b0, intr_en_q};
      if (s_addr == ADDR_W'(OFS_STATUS)) s_dout = {30'b0, busy, done};
      if (s_addr == ADDR_W'(OFS_MODE))   s_dout = {31'b0, mode_q};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Operand, result and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: RESULT is a flop vector, not a RAM, so it is cleared by reset like the rest.
    if (!reset_n) begin
      op_a_q    <= '0;
      op_b_q    <= '0;
      result_q  <= '0;
      acc_q     <= '0;
      mplr_q    <= '0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      intr_en_q <= 1'b0;
      mode_q    <= 1'b0;
    end else begin
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      result_q  <= result_d;
      acc_q     <= acc_d;
      mplr_q    <= mplr_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      intr_en_q <= intr_en_d;
      mode_q    <= mode_d;
    end
  end

endmodule

// File: tb/tb_mul_booth_slave.sv
// tb_mul_booth_slave: directed vectors for the default radix-4 64-bit build
// plus a radix-2 32-bit build, with hand-computed products.
module tb_mul_booth_slave;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sel0, wr0, sel1, wr1;
  logic [3:0]  addr0, addr1;
  logic [31:0] din0, din1, dout0, dout1;
  logic        irq0, irq1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_booth_slave #(.N_WORDS(2), .RADIX4(1), .ADDR_W(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .s_sel(sel0), .s_wr(wr0), .s_addr(addr0),
    .s_din(din0), .s_dout(dout0), .m_interrupt(irq0)
  );

  mul_booth_slave #(.N_WORDS(1), .RADIX4(0), .ADDR_W(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .s_sel(sel1), .s_wr(wr1), .s_addr(addr1),
    .s_din(din1), .s_dout(dout1), .m_interrupt(irq1)
  );

  typedef struct {
    logic         mode;
    logic [63:0]  a;
    logic [63:0]  b;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input int d, input int addr, input logic [31:0] data);
    @(negedge clk);
    if (d == 0) begin sel0 = 1'b1; wr0 = 1'b1; addr0 = 4'(addr); din0 = data; end
    else        begin sel1 = 1'b1; wr1 = 1'b1; addr1 = 4'(addr); din1 = data; end
    @(posedge clk);
    #1;
    sel0 = 1'b0; wr0 = 1'b0; sel1 = 1'b0; wr1 = 1'b0;
  endtask

  task automatic bus_read(input int d, input int addr, output logic [31:0] data);
    @(negedge clk);
    if (d == 0) begin sel0 = 1'b1; wr0 = 1'b0; addr0 = 4'(addr); end
    else        begin sel1 = 1'b1; wr1 = 1'b0; addr1 = 4'(addr); end
    #1;
    data = (d == 0) ? dout0 : dout1;
    sel0 = 1'b0; sel1 = 1'b0;
  endtask

  // Counts rising edges until the interrupt is seen, bounded at 200.
  task automatic wait_irq(input int d, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!((d == 0) ? irq0 : irq1) && cyc < 200);
  endtask

  task automatic read_result(input int d, input int n, output logic [127:0] res);
    logic [31:0] w;
    res = '0;
    for (int i = 0; i < 2 * n; i++) begin
      bus_read(d, 2 * n + i, w);
      res[i*32 +: 32] = w;
    end
  endtask

  // Loads mode and operands, enables the IRQ, starts, and measures latency.
  task automatic run_op(input int d, input int n, input logic mode,
                        input logic [63:0] a, input logic [63:0] b, output int lat);
    bus_write(d, 4 * n + 4, {31'b0, mode});
    for (int i = 0; i < n; i++) begin
      bus_write(d, i, a[i*32 +: 32]);
      bus_write(d, n + i, b[i*32 +: 32]);
    end
    bus_write(d, 4 * n + 2, 32'd1);
    bus_write(d, 4 * n, 32'd1);
    wait_irq(d, lat);
  endtask

  initial begin
    logic [31:0]  rd;
    logic [127:0] res;
    int           lat;

    vecs[0] = '{1'b0, 64'd20, 64'd20, 128'd400};
    vecs[1] = '{1'b1, 64'd20, 64'hFFFF_FFFF_FFFF_FFEC, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FE70};
    vecs[2] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
    vecs[3] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 128'd1};
    vecs[4] = '{1'b0, 64'h0000_0001_0000_0000, 64'd3, 128'h3_0000_0000};
    vecs[5] = '{1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                128'h4000_0000_0000_0000_0000_0000_0000_0000};
    vecs[6] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFB};

    reset_n = 1'b0;
    sel0 = 1'b0; wr0 = 1'b0; addr0 = '0; din0 = '0;
    sel1 = 1'b0; wr1 = 1'b0; addr1 = '0; din1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset state: every offset reads 0, no interrupt, idle bus output 0.
    check("reset_irq", 128'(irq0), 128'd0);
    check("reset_dout_idle", 128'(dout0), 128'd0);
    for (int i = 0; i < 16; i++) begin
      bus_read(0, i, rd);
      check($sformatf("reset_rd_%0d", i), 128'(rd), 128'd0);
    end

    // Table-driven products with latency, status and interrupt handshake.
    for (int v = 0; v < 7; v++) begin
      run_op(0, 2, vecs[v].mode, vecs[v].a, vecs[v].b, lat);
      check($sformatf("v%0d_latency", v), 128'(lat), 128'd33);
      read_result(0, 2, res);
      check($sformatf("v%0d_result", v), res, vecs[v].exp);
      bus_read(0, 11, rd);
      check($sformatf("v%0d_status_done", v), 128'(rd), 128'd1);
      bus_write(0, 11, 32'd1);
      check($sformatf("v%0d_irq_cleared", v), 128'(irq0), 128'd0);
      bus_read(0, 11, rd);
      check($sformatf("v%0d_status_clr", v), 128'(rd), 128'd0);
      read_result(0, 2, res);
      check($sformatf("v%0d_result_kept", v), res, vecs[v].exp);
    end

    // Busy protection: operand write during EXEC is dropped.
    bus_write(0, 12, 32'd0);
    bus_write(0, 0, 32'd20); bus_write(0, 1, 32'd0);
    bus_write(0, 2, 32'd20); bus_write(0, 3, 32'd0);
    bus_write(0, 8, 32'd1);
    repeat (2) @(posedge clk);
    bus_write(0, 0, 32'd5);
    bus_write(0, 12, 32'd1);
    bus_read(0, 11, rd);
    check("busy_status", 128'(rd), 128'd2);
    bus_read(0, 0, rd);
    check("busy_a_kept", 128'(rd), 128'd20);
    bus_read(0, 12, rd);
    check("busy_mode_kept", 128'(rd), 128'd0);
    wait_irq(0, lat);
    check("busy_irq_seen", 128'(irq0), 128'd1);
    read_result(0, 2, res);
    check("busy_result", res, 128'd400);

    // Back-to-back: OPSTART in the first DONE cycle restarts with full latency.
    bus_write(0, 8, 32'd1);
    wait_irq(0, lat);
    bus_write(0, 8, 32'd1);
    check("b2b_irq_dropped", 128'(irq0), 128'd0);
    wait_irq(0, lat);
    check("b2b_latency", 128'(lat), 128'd33);
    read_result(0, 2, res);
    check("b2b_result", res, 128'd400);

    // Abort: OPCLEAR mid-EXEC returns to IDLE with RESULT cleared, operands kept.
    bus_write(0, 8, 32'd1);
    repeat (8) @(posedge clk);
    bus_write(0, 9, 32'd1);
    bus_read(0, 11, rd);
    check("abort_status", 128'(rd), 128'd0);
    read_result(0, 2, res);
    check("abort_result", res, 128'd0);
    bus_read(0, 0, rd);
    check("abort_a_kept", 128'(rd), 128'd20);
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_irq", 128'(irq0), 128'd0);

    // Reset mid-EXEC: everything reads 0 afterwards.
    bus_write(0, 8, 32'd1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_irq", 128'(irq0), 128'd0);
    for (int i = 0; i < 16; i++) begin
      bus_read(0, i, rd);
      check($sformatf("rst_rd_%0d", i), 128'(rd), 128'd0);
    end
    repeat (40) @(posedge clk);
    #1;
    check("rst_no_irq", 128'(irq0), 128'd0);

    // Radix-2, 32-bit build: signed 7 x -3 and unsigned 7 x 0xFFFFFFFD.
    run_op(1, 1, 1'b1, 64'd7, 64'hFFFF_FFFD, lat);
    check("r2_signed_latency", 128'(lat), 128'd33);
    read_result(1, 1, res);
    check("r2_signed_result", res, 128'hFFFF_FFFF_FFFF_FFEB);
    bus_read(1, 7, rd);
    check("r2_status_done", 128'(rd), 128'd1);
    bus_write(1, 7, 32'd1);
    check("r2_irq_cleared", 128'(irq1), 128'd0);
    run_op(1, 1, 1'b0, 64'd7, 64'hFFFF_FFFD, lat);
    check("r2_unsigned_latency", 128'(lat), 128'd33);
    read_result(1, 1, res);
    check("r2_unsigned_result", res, 128'h6_FFFF_FFEB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
